// File: rtl/tlb_cp0_ctrl_if.sv
// Request/response bus between the CP0 TLB-instruction controller and the TLB.
// The controller drives the request side and receives the completion plus results.
interface tlb_cp0_ctrl_if;
    logic [2:0]  tlb_req;
    logic [4:0]  req_index;
    logic [31:0] req_entryhi;
    logic [31:0] req_entrylo0;
    logic [31:0] req_entrylo1;
    logic        tlb_ok;
    logic [31:0] res_index;
    logic [31:0] res_entryhi;
    logic [31:0] res_entrylo0;
    logic [31:0] res_entrylo1;

    modport master (
        output tlb_req, req_index, req_entryhi, req_entrylo0, req_entrylo1,
        input  tlb_ok, res_index, res_entryhi, res_entrylo0, res_entrylo1
    );

    modport slave (
        input  tlb_req, req_index, req_entryhi, req_entrylo0, req_entrylo1,
        output tlb_ok, res_index, res_entryhi, res_entrylo0, res_entrylo1
    );
endinterface

// File: rtl/tlb_cp0_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from commit into TLB requests, CP0 writebacks
// and a request timeout; also owns the CP0 Random register.
module tlb_cp0_ctrl (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  op_valid,
    input  logic [1:0]            op_code,
    input  logic                  flush,
    input  logic [31:0]           cp0_index,
    input  logic [31:0]           cp0_entryhi,
    input  logic [31:0]           cp0_entrylo0,
    input  logic [31:0]           cp0_entrylo1,
    input  logic [4:0]            cp0_wired,
    input  logic                  wired_we,
    tlb_cp0_ctrl_if.master        tlb,
    output logic                  stall,
    output logic                  wb_index_we,
    output logic                  wb_entry_we,
    output logic [31:0]           wb_index,
    output logic [31:0]           wb_entryhi,
    output logic [31:0]           wb_entrylo0,
    output logic [31:0]           wb_entrylo1,
    output logic [4:0]            random,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    function automatic logic [31:0] mask_entrylo(input logic [31:0] lo);
        return lo & 32'h03FF_FFFF;
    endfunction

    // Probe result: miss keeps only the P bit, hit keeps the 5-bit index.
    function automatic logic [31:0] probe_index(input logic [31:0] idx);
        return idx[31] ? 32'h8000_0000 : (idx & 32'h0000_001F);
    endfunction

    state_t      state_r;
    logic [1:0]  op_r;
    logic [3:0]  tmo_cnt_r;
    logic [2:0]  tlb_req_r;
    logic [4:0]  req_index_r;
    logic [31:0] req_entryhi_r;
    logic [31:0] req_entrylo0_r;
    logic [31:0] req_entrylo1_r;
    logic        wb_index_we_r;
    logic        wb_entry_we_r;
    logic [31:0] wb_index_r;
    logic [31:0] wb_entryhi_r;
    logic [31:0] wb_entrylo0_r;
    logic [31:0] wb_entrylo1_r;
    logic [4:0]  random_r;
    logic        timeout_err_r;
    logic        accept_s;

    assign accept_s = (state_r == ST_IDLE) & op_valid & ~flush;

    // Stall must rise in the accept cycle itself, so it is combinational.
    assign stall = (state_r != ST_IDLE) | (op_valid & ~flush);

    assign tlb.tlb_req      = tlb_req_r;
    assign tlb.req_index    = req_index_r;
    assign tlb.req_entryhi  = req_entryhi_r;
    assign tlb.req_entrylo0 = req_entrylo0_r;
    assign tlb.req_entrylo1 = req_entrylo1_r;
    assign wb_index_we      = wb_index_we_r;
    assign wb_entry_we      = wb_entry_we_r;
    assign wb_index         = wb_index_r;
    assign wb_entryhi       = wb_entryhi_r;
    assign wb_entrylo0      = wb_entrylo0_r;
    assign wb_entrylo1      = wb_entrylo1_r;
    assign random           = random_r;
    assign timeout_err      = timeout_err_r;

    // Random register: free-running down-counter that wraps to 31 at Wired or 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_r <= 5'd31;
        end else if (wired_we) begin
            random_r <= 5'd31;
        end else if ((random_r == cp0_wired) || (random_r == 5'd0)) begin
            random_r <= 5'd31;
        end else begin
            random_r <= random_r - 5'd1;
        end
    end

    // Operation FSM: accept, hold request until completion or timeout, one-cycle writeback.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            op_r           <= 2'd0;
            tmo_cnt_r      <= 4'd0;
            tlb_req_r      <= 3'd0;
            req_index_r    <= 5'd0;
            req_entryhi_r  <= 32'd0;
            req_entrylo0_r <= 32'd0;
            req_entrylo1_r <= 32'd0;
            wb_index_we_r  <= 1'b0;
            wb_entry_we_r  <= 1'b0;
            wb_index_r     <= 32'd0;
            wb_entryhi_r   <= 32'd0;
            wb_entrylo0_r  <= 32'd0;
            wb_entrylo1_r  <= 32'd0;
            timeout_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wb_index_we_r <= 1'b0;
                    wb_entry_we_r <= 1'b0;
                    timeout_err_r <= 1'b0;
                    if (accept_s) begin
                        op_r           <= op_code;
                        tmo_cnt_r      <= 4'd0;
                        tlb_req_r      <= {1'b0, op_code} + 3'd1;
                        req_index_r    <= (op_code == OP_TLBWR) ? random_r : 5'(cp0_index);
                        req_entryhi_r  <= cp0_entryhi;
                        req_entrylo0_r <= mask_entrylo(cp0_entrylo0);
                        req_entrylo1_r <= mask_entrylo(cp0_entrylo1);
                        state_r        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tlb.tlb_ok) begin
                        wb_index_r    <= probe_index(tlb.res_index);
                        wb_entryhi_r  <= tlb.res_entryhi & 32'hFFFF_E0FF;
                        wb_entrylo0_r <= mask_entrylo(tlb.res_entrylo0);
                        wb_entrylo1_r <= mask_entrylo(tlb.res_entrylo1);
                        wb_index_we_r <= (op_r == OP_TLBP);
                        wb_entry_we_r <= (op_r == OP_TLBR);
                        tlb_req_r     <= 3'd0;
                        state_r       <= ST_WB;
                    end else if (tmo_cnt_r == 4'd14) begin
                        // Count reaches 15 on this edge: fifteen unanswered REQ cycles.
                        tmo_cnt_r     <= 4'd15;
                        timeout_err_r <= 1'b1;
                        tlb_req_r     <= 3'd0;
                        state_r       <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 4'd1;
                    end
                end
                ST_WB: begin
                    wb_index_we_r <= 1'b0;
                    wb_entry_we_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    tlb_req_r     <= 3'd0;
                    wb_index_we_r <= 1'b0;
                    wb_entry_we_r <= 1'b0;
                    timeout_err_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Scoreboard bench for tlb_cp0_ctrl: expected requests/writebacks are queued when an
// op is driven and compared when the request appears and when it retires.
module tb_tlb_cp0_ctrl;

    typedef struct packed {
        logic [2:0]  req;
        logic [4:0]  index;
        logic [31:0] ehi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } rq_t;

    // kind: 0 no writeback, 1 index write, 2 entry write, 3 timeout
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] index;
        logic [31:0] ehi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } wq_t;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        flush;
    logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic [4:0]  cp0_wired;
    logic        wired_we;
    logic        stall, wb_index_we, wb_entry_we, timeout_err;
    logic [31:0] wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1;
    logic [4:0]  random;

    tlb_cp0_ctrl_if tlb_bus ();

    tlb_cp0_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op_code      (op_code),
        .flush        (flush),
        .cp0_index    (cp0_index),
        .cp0_entryhi  (cp0_entryhi),
        .cp0_entrylo0 (cp0_entrylo0),
        .cp0_entrylo1 (cp0_entrylo1),
        .cp0_wired    (cp0_wired),
        .wired_we     (wired_we),
        .tlb          (tlb_bus),
        .stall        (stall),
        .wb_index_we  (wb_index_we),
        .wb_entry_we  (wb_entry_we),
        .wb_index     (wb_index),
        .wb_entryhi   (wb_entryhi),
        .wb_entrylo0  (wb_entrylo0),
        .wb_entrylo1  (wb_entrylo1),
        .random       (random),
        .timeout_err  (timeout_err)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    int  tlb_lat  = 0;
    rq_t req_q[$];
    wq_t wb_q[$];
    logic [4:0] rand_m;
    logic [2:0] prev_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference Random register, straight from the update rule.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) rand_m <= 5'd31;
        else if (wired_we) rand_m <= 5'd31;
        else if (rand_m == cp0_wired || rand_m == 5'd0) rand_m <= 5'd31;
        else rand_m <= rand_m - 5'd1;
    end

    // TLB responder: answers tlb_lat REQ cycles after the request appears.
    initial begin
        int n;
        n = 0;
        tlb_bus.tlb_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && tlb_bus.tlb_req != 3'd0) begin
                tlb_bus.tlb_ok = (n == tlb_lat);
                n++;
            end else begin
                tlb_bus.tlb_ok = 1'b0;
                n = 0;
            end
        end
    end

    // Monitor: request start and request retirement pop the scoreboard.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_req <= 3'd0;
        end else begin
            check_eq("random", 32'(random), 32'(rand_m));
            if (prev_req == 3'd0 && tlb_bus.tlb_req != 3'd0) begin
                if (req_q.size() == 0) check_eq("req_underflow", 32'd1, 32'd0);
                else begin
                    check_eq("tlb_req", 32'(tlb_bus.tlb_req), 32'(req_q[0].req));
                    check_eq("req_index", 32'(tlb_bus.req_index), 32'(req_q[0].index));
                    check_eq("req_entryhi", tlb_bus.req_entryhi, req_q[0].ehi);
                    check_eq("req_entrylo0", tlb_bus.req_entrylo0, req_q[0].lo0);
                    check_eq("req_entrylo1", tlb_bus.req_entrylo1, req_q[0].lo1);
                    void'(req_q.pop_front());
                end
            end
            if (prev_req != 3'd0 && tlb_bus.tlb_req == 3'd0) begin
                if (wb_q.size() == 0) check_eq("wb_underflow", 32'd1, 32'd0);
                else begin
                    check_eq("wb_index_we", 32'(wb_index_we), 32'(wb_q[0].kind == 2'd1));
                    check_eq("wb_entry_we", 32'(wb_entry_we), 32'(wb_q[0].kind == 2'd2));
                    check_eq("timeout_err", 32'(timeout_err), 32'(wb_q[0].kind == 2'd3));
                    if (wb_q[0].kind == 2'd1) check_eq("wb_index", wb_index, wb_q[0].index);
                    if (wb_q[0].kind == 2'd2) begin
                        check_eq("wb_entryhi", wb_entryhi, wb_q[0].ehi);
                        check_eq("wb_entrylo0", wb_entrylo0, wb_q[0].lo0);
                        check_eq("wb_entrylo1", wb_entrylo1, wb_q[0].lo1);
                    end
                    void'(wb_q.pop_front());
                end
            end
            prev_req <= tlb_bus.tlb_req;
        end
    end

    // Call at a falling edge; drives one op, queues expectations and waits for retirement.
    task automatic do_op(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] ehi,
                         input logic [31:0] lo0, input logic [31:0] lo1,
                         input logic [31:0] r_idx, input logic [31:0] r_ehi,
                         input logic [31:0] r_lo0, input logic [31:0] r_lo1,
                         input int lat, input bit noisy, input int exp_stall);
        rq_t r;
        wq_t w;
        int  n;
        tlb_lat = lat;
        tlb_bus.res_index = r_idx;   tlb_bus.res_entryhi = r_ehi;
        tlb_bus.res_entrylo0 = r_lo0; tlb_bus.res_entrylo1 = r_lo1;
        op_valid = 1'b1; flush = 1'b0; op_code = op;
        cp0_index = idx; cp0_entryhi = ehi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
        r.req   = {1'b0, op} + 3'd1;
        r.index = (op == 2'd3) ? rand_m : idx[4:0];
        r.ehi   = ehi;
        r.lo0   = lo0 & 32'h03FF_FFFF;
        r.lo1   = lo1 & 32'h03FF_FFFF;
        w.kind  = (lat >= 15) ? 2'd3 : (op == 2'd0) ? 2'd1 : (op == 2'd1) ? 2'd2 : 2'd0;
        w.index = r_idx[31] ? 32'h8000_0000 : {27'd0, r_idx[4:0]};
        w.ehi   = r_ehi & 32'hFFFF_E0FF;
        w.lo0   = r_lo0 & 32'h03FF_FFFF;
        w.lo1   = r_lo1 & 32'h03FF_FFFF;
        req_q.push_back(r);
        wb_q.push_back(w);
        #1 check_eq("stall_accept", 32'(stall), 32'd1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            op_valid = noisy; flush = noisy;
            if (noisy) op_code = 2'($urandom_range(0, 3));
            #1;
            if (!stall) break;
            n++;
        end
        op_valid = 1'b0; flush = 1'b0;
        check_eq("stall_cycles", 32'(n), 32'(exp_stall));
        check_eq("we_after_wb", 32'({wb_index_we, wb_entry_we}), 32'd0);
        @(negedge clk);
        check_eq("tmo_pulse_end", 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op_code = 2'd0; flush = 1'b0;
        cp0_index = 32'd0; cp0_entryhi = 32'd0; cp0_entrylo0 = 32'd0; cp0_entrylo1 = 32'd0;
        cp0_wired = 5'd0; wired_we = 1'b0;
        tlb_bus.res_index = 32'd0; tlb_bus.res_entryhi = 32'd0;
        tlb_bus.res_entrylo0 = 32'd0; tlb_bus.res_entrylo1 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_tlb_req", 32'(tlb_bus.tlb_req), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_we", 32'({wb_index_we, wb_entry_we, timeout_err}), 32'd0);
        check_eq("rst_random", 32'(random), 32'd31);
        check_eq("rst_wb_index", wb_index, 32'd0);
        check_eq("rst_req_index", 32'(tlb_bus.req_index), 32'd0);
        check_eq("rst_wb_entryhi", wb_entryhi, 32'd0);
        @(negedge clk); resetn = 1'b1;

        // TLBP hit, minimum latency
        @(negedge clk);
        do_op(2'd0, 32'd0, 32'h0000_2005, 32'd0, 32'd0,
              32'h0000_0003, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3);
        // TLBP hit with junk above the index field
        @(negedge clk);
        do_op(2'd0, 32'd5, 32'h1234_5000, 32'd0, 32'd0,
              32'h1234_5663, 32'd0, 32'd0, 32'd0, 1, 1'b0, 4);
        // TLBP miss
        @(negedge clk);
        do_op(2'd0, 32'd0, 32'h0000_4000, 32'd0, 32'd0,
              32'h8000_0000, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3);
        // TLBR with masking of EntryHi and EntryLo
        @(negedge clk);
        do_op(2'd1, 32'hABCD_EF07, 32'h0000_6000, 32'hFFFF_FFFF, 32'hFC00_0001,
              32'd0, 32'hFFFF_FFFF, 32'hFC00_1234, 32'hFFFF_FFFF, 2, 1'b0, 5);
        // TLBWI, no writeback
        @(negedge clk);
        do_op(2'd2, 32'h0000_001F, 32'h8000_2000, 32'hFFFF_FFFF, 32'h0400_0003,
              32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3);
        // TLBR answered in the last REQ cycle before timeout, with op_valid/flush noise
        @(negedge clk);
        do_op(2'd1, 32'd9, 32'd0, 32'd0, 32'd0,
              32'd0, 32'hA5A5_A5A5, 32'h0123_4567, 32'hF765_4321, 14, 1'b1, 17);
        // Timeout: no answer
        @(negedge clk);
        do_op(2'd0, 32'd1, 32'h0000_2000, 32'd0, 32'd0,
              32'h0000_0002, 32'd0, 32'd0, 32'd0, 100, 1'b0, 16);

        // Wired=4: reload then 31 down to 4, then back to 31
        @(negedge clk); cp0_wired = 5'd4; wired_we = 1'b1;
        @(negedge clk); wired_we = 1'b0;
        for (int v = 31; v >= 4; v--) begin
            check_eq("rand_seq", 32'(random), 32'(v));
            @(negedge clk);
        end
        check_eq("rand_wrap", 32'(random), 32'd31);
        // TLBWR under Wired=4 uses Random at accept
        repeat (3) @(negedge clk);
        do_op(2'd3, 32'd2, 32'h0000_8000, 32'h0000_0007, 32'h0000_0005,
              32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3);
        @(negedge clk);
        do_op(2'd3, 32'd2, 32'h0000_A000, 32'd0, 32'd0,
              32'd0, 32'd0, 32'd0, 32'd0, 3, 1'b0, 6);

        // Wired=31 pins Random at 31
        @(negedge clk); cp0_wired = 5'd31; wired_we = 1'b1;
        @(negedge clk); wired_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("rand_wired31", 32'(random), 32'd31);
            @(negedge clk);
        end
        cp0_wired = 5'd0;

        // op_valid with flush is not accepted
        @(negedge clk); op_valid = 1'b1; flush = 1'b1; op_code = 2'd1;
        #1 check_eq("flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check_eq("flush_noreq", 32'(tlb_bus.tlb_req), 32'd0);
        op_valid = 1'b0; flush = 1'b0;

        // Reset during REQ drops the request
        @(negedge clk);
        tlb_lat = 100;
        op_valid = 1'b1; op_code = 2'd2; cp0_index = 32'd6; cp0_entryhi = 32'h0000_C000;
        cp0_entrylo0 = 32'd0; cp0_entrylo1 = 32'd0;
        req_q.push_back('{req: 3'd3, index: 5'd6, ehi: 32'h0000_C000, lo0: 32'd0, lo1: 32'd0});
        @(negedge clk); op_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("rstmid_tlb_req", 32'(tlb_bus.tlb_req), 32'd0);
        check_eq("rstmid_random", 32'(random), 32'd31);
        check_eq("rstmid_stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        // Accepted in the first cycle after release
        do_op(2'd0, 32'd0, 32'h0000_2005, 32'd0, 32'd0,
              32'h0000_0011, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3);

        repeat (2) @(negedge clk);
        check_eq("req_q_empty", 32'(req_q.size()), 32'd0);
        check_eq("wb_q_empty", 32'(wb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_cp0_ctrl.md
TLB_CP0_CTRL -- requirements
Module: tlb_cp0_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have port op_valid, input, 1 bit: a TLB instruction is present at the commit stage.
REQ-004 SHALL have port op_code, input, 2 bits: 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-005 SHALL have port flush, input, 1 bit: exception or eret flush in progress.
REQ-006 SHALL have ports cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, inputs, 32 bits each: current CP0 register values.
REQ-007 SHALL have port cp0_wired, input, 5 bits: the Wired register value.
REQ-008 SHALL have port wired_we, input, 1 bit: Wired is being written this cycle.
REQ-009 SHALL have port tlb_req, output, 3 bits, toward the TLB: 0 NO_REQ, 1 TLBP, 2 TLBR, 3 TLBWI, 4 TLBWR.
REQ-010 SHALL have ports req_index (5 bits), req_entryhi, req_entrylo0 and req_entrylo1 (32 bits each), outputs: the request operands.
REQ-011 SHALL have port tlb_ok, input, 1 bit: the TLB has completed the request (registered, and concurrent with the result).
REQ-012 SHALL have ports res_index, res_entryhi, res_entrylo0, res_entrylo1, inputs, 32 bits each: TLB results, valid while tlb_ok=1.
REQ-013 SHALL have port stall, output, 1 bit: hold the pipeline.
REQ-014 SHALL have ports wb_index_we and wb_entry_we, outputs, 1 bit each: CP0 write enables.
REQ-015 SHALL have ports wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1, outputs, 32 bits each: CP0 write data.
REQ-016 SHALL have port random, output, 5 bits: the CP0 Random register.
REQ-017 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on request timeout.

Function
REQ-018 SHALL implement FSM states IDLE, REQ and WB.
REQ-019 IDLE: when op_valid=1 and flush=0, SHALL latch the following, clear the timeout counter, and enter REQ:
- op_code;
- cp0_index[4:0], or random when op_code=TLBWR;
- cp0_entryhi;
- cp0_entrylo0/1 with bits [31:26] forced to 0.
REQ-020 stall SHALL equal (state!=IDLE) | (op_valid & ~flush) as a combinational function, so stall is asserted in the accept cycle.
REQ-021 In REQ, tlb_req SHALL carry the latched op code and operands SHALL hold the latched values; in every other state tlb_req=0.
REQ-022 REQ exit on tlb_ok=1:
- SHALL capture res_* into wb_* registers and enter WB.
- TLBP: wb_index=0x8000_0000 if res_index[31]=1, else {27'b0,res_index[4:0]}.
- TLBR: wb_entryhi=res_entryhi & 0xFFFF_E0FF; wb_entrylo0 and wb_entrylo1 equal res_* with bits [31:26] forced to 0.
REQ-023 WB SHALL last exactly one cycle.
- wb_index_we=1 only for TLBP.
- wb_entry_we=1 only for TLBR.
- Both enables 0 for TLBWI and TLBWR.
- Then return to IDLE.
REQ-024 Timeout: in REQ, a 4-bit counter SHALL increment each cycle with tlb_ok=0. On count 15, SHALL return to IDLE, pulse timeout_err for one cycle, and perform no writeback.
REQ-025 op_valid while state!=IDLE SHALL be ignored; flush in REQ or WB SHALL NOT abort the operation.
REQ-026 Minimum latency accept-to-IDLE SHALL be 3 cycles (accept, REQ with tlb_ok at the next edge, WB).
REQ-027 Random update each cycle, in priority order:
- wired_we=1: load 31;
- random==cp0_wired or random==0: load 31;
- otherwise: decrement by 1.
REQ-028 Random SHALL keep counting during every FSM state; TLBWR SHALL use the value latched at accept.
REQ-029 If cp0_wired>31 cannot occur (5 bits) and cp0_wired=31, random SHALL remain at 31.

Reset
REQ-030 On resetn=0, asynchronously:
- state=IDLE;
- tlb_req=0;
- stall, wb_*_we and timeout_err = 0;
- wb_* data, req_* operands and the timeout counter = 0;
- random=31.
REQ-031 Reset mid-REQ SHALL drop the request with no writeback; after release the block SHALL accept a new op in its first cycle.

Verification
REQ-032 TLBP: entryhi=0x0000_2005, TLB returns tlb_ok with res_index=3 one cycle after REQ. Required: wb_index=0x0000_0003 with wb_index_we=1 for one cycle; stall=1 for 3 cycles.
REQ-033 TLBP miss: res_index=0x8000_0000. Required: wb_index=0x8000_0000, wb_entry_we=0.
REQ-034 TLBR: cp0_index=7, res_entryhi=0xFFFF_FFFF. Required: wb_entryhi=0xFFFF_E0FF, req_index=7, wb_entry_we pulses once.
REQ-035 TLBWR with cp0_wired=4: random counts 31..4 then reloads 31. Required: req_index equals random at the accept cycle; wired_we reloads random to 31.
REQ-036 Timeout: tlb_ok held at 0. Required: timeout_err pulses once after 15 REQ cycles, no write enables, IDLE afterwards.
REQ-037 Flush and reset: op_valid together with flush=1 is not accepted (stall=0); resetn dropped during REQ gives tlb_req=0 and random=31 immediately.
